// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg
// Definitions shared by the divide sequencing controller and the ALU that
// instantiates it: FSM state encodings, start-pulse levels and the default
// watchdog limit.
package div_seq_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Levels driven on the divider start line
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Default watchdog limit in BUSY cycles (legal range 2..255)
  localparam int DIV_TIMEOUT_DEFAULT = 64;

  // Width of the watchdog counter; wide enough for the largest legal limit
  localparam int DIV_CNT_W = 8;

endpackage

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
// Sequencing controller between the EX stage and the iterative divider.
// A DIV/DIVU request seen in IDLE is latched and launched with one start
// pulse; the pipeline is stalled until the divider reports ready (or the
// watchdog expires), and the 64-bit {remainder, quotient} is then offered to
// the HI/LO write port exactly once, when the instruction leaves EX.
//
// Parameters:
//   WIDTH    operand width, result is 2*WIDTH
//   TIMEOUT  BUSY cycles before the watchdog aborts (2..255)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         EX holds a DIV/DIVU
//   req_signed        1 = DIV, 0 = DIVU
//   op_a, op_b        dividend, divisor
//   flush             kill the EX instruction
//   stall_in          EX held by another stall source
//   stall_div         stall request to the hazard unit (combinational)
//   div_start         divider start pulse
//   div_signed        divider signed select
//   div_annul         divider abort pulse
//   div_opa, div_opb  latched operands
//   div_ready         divider result valid
//   div_result        {remainder, quotient} from the divider
//   hilo_we           HI/LO write enable (combinational, DONE only)
//   hilo_wdata        {HI, LO} = {remainder, quotient}
//   div_err           watchdog timeout pulse
//
// Optional build macro:
//   DIV_ZERO_FAST_EN  a request with op_b == 0 bypasses the divider and
//                     retires {op_a, all-ones} directly.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 flush,
  input  logic                 stall_in,
  output logic                 stall_div,
  output logic                 div_start,
  output logic                 div_signed,
  output logic                 div_annul,
  output logic [WIDTH-1:0]     div_opa,
  output logic [WIDTH-1:0]     div_opb,
  input  logic                 div_ready,
  input  logic [2*WIDTH-1:0]   div_result,
  output logic                 hilo_we,
  output logic [2*WIDTH-1:0]   hilo_wdata,
  output logic                 div_err
);

  // Counter value seen during the last BUSY cycle the watchdog allows
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(TIMEOUT - 1);

  div_state_e             state_r, state_nxt_s;
  logic [DIV_CNT_W-1:0]   cnt_r, cnt_nxt_s;

  logic                   start_r, start_nxt_s;
  logic                   signed_r, signed_nxt_s;
  logic                   annul_r, annul_nxt_s;
  logic                   err_r, err_nxt_s;
  logic [WIDTH-1:0]       opa_r, opa_nxt_s;
  logic [WIDTH-1:0]       opb_r, opb_nxt_s;
  logic [2*WIDTH-1:0]     wdata_r, wdata_nxt_s;

  logic                   stall_div_s;
  logic                   hilo_we_s;

  // Next-state, next-register and combinational output decode
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    start_nxt_s  = DIV_STOP;
    annul_nxt_s  = 1'b0;
    err_nxt_s    = 1'b0;
    signed_nxt_s = signed_r;
    opa_nxt_s    = opa_r;
    opb_nxt_s    = opb_r;
    wdata_nxt_s  = wdata_r;
    stall_div_s  = 1'b0;
    hilo_we_s    = 1'b0;

    case (state_r)
      DIV_IDLE: begin
        cnt_nxt_s   = {DIV_CNT_W{1'b0}};
        // Stall already in the first EX cycle of the divide
        stall_div_s = req_valid & ~flush;
        if (req_valid && !flush) begin
          opa_nxt_s    = op_a;
          opb_nxt_s    = op_b;
          signed_nxt_s = req_signed;
`ifdef DIV_ZERO_FAST_EN
          if (op_b == {WIDTH{1'b0}}) begin
            wdata_nxt_s = {op_a, {WIDTH{1'b1}}};
            state_nxt_s = DIV_DONE;
          end else begin
            start_nxt_s = DIV_START;
            state_nxt_s = DIV_BUSY;
          end
`else
          start_nxt_s = DIV_START;
          state_nxt_s = DIV_BUSY;
`endif
        end else begin
          state_nxt_s = DIV_IDLE;
        end
      end

      DIV_BUSY: begin
        stall_div_s = 1'b1;
        // Flush beats a simultaneous ready; ready beats the watchdog
        if (flush) begin
          annul_nxt_s = 1'b1;
          cnt_nxt_s   = {DIV_CNT_W{1'b0}};
          state_nxt_s = DIV_IDLE;
        end else if (div_ready) begin
          wdata_nxt_s = div_result;
          cnt_nxt_s   = {DIV_CNT_W{1'b0}};
          state_nxt_s = DIV_DONE;
        end else if (cnt_r == CNT_LAST) begin
          // Retire with HI/LO = 0 rather than hanging the pipeline
          annul_nxt_s = 1'b1;
          err_nxt_s   = 1'b1;
          wdata_nxt_s = {(2*WIDTH){1'b0}};
          cnt_nxt_s   = {DIV_CNT_W{1'b0}};
          state_nxt_s = DIV_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
          state_nxt_s = DIV_BUSY;
        end
      end

      DIV_DONE: begin
        // Write only on the cycle the instruction actually leaves EX
        hilo_we_s = ~stall_in & ~flush;
        if (!stall_in || flush) begin
          state_nxt_s = DIV_IDLE;
        end else begin
          state_nxt_s = DIV_DONE;
        end
      end

      default: begin
        state_nxt_s = DIV_IDLE;
        cnt_nxt_s   = {DIV_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
      cnt_r   <= {DIV_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered divider-side and HI/LO outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r  <= DIV_STOP;
      signed_r <= 1'b0;
      annul_r  <= 1'b0;
      err_r    <= 1'b0;
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      wdata_r  <= {(2*WIDTH){1'b0}};
    end else begin
      start_r  <= start_nxt_s;
      signed_r <= signed_nxt_s;
      annul_r  <= annul_nxt_s;
      err_r    <= err_nxt_s;
      opa_r    <= opa_nxt_s;
      opb_r    <= opb_nxt_s;
      wdata_r  <= wdata_nxt_s;
    end
  end

  assign stall_div  = stall_div_s;
  assign hilo_we    = hilo_we_s;
  assign div_start  = start_r;
  assign div_signed = signed_r;
  assign div_annul  = annul_r;
  assign div_err    = err_r;
  assign div_opa    = opa_r;
  assign div_opb    = opb_r;
  assign hilo_wdata = wdata_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl
// Self-checking bench for div_seq_ctrl. Each transaction is turned into a
// per-cycle timeline of stimulus and expected outputs from the behavioural
// rules (request cycle, BUSY window ended by flush / ready / watchdog, DONE
// held by stall_in); one compare process checks every cycle against it.
// The bench also plays the divider, answering with an arithmetic quotient.
module tb_div_seq_ctrl;

  localparam int W    = 32;
  localparam int TO   = 64;
  localparam int MAXC = 128;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_signed, flush, stall_in, div_ready;
  logic [W-1:0]  op_a, op_b;
  logic [2*W-1:0] div_result;
  logic          stall_div, div_start, div_signed, div_annul, hilo_we, div_err;
  logic [W-1:0]  div_opa, div_opb;
  logic [2*W-1:0] hilo_wdata;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall_in(stall_in),
    .stall_div(stall_div), .div_start(div_start), .div_signed(div_signed),
    .div_annul(div_annul), .div_opa(div_opa), .div_opb(div_opb),
    .div_ready(div_ready), .div_result(div_result), .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata), .div_err(div_err)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus and expectations for the current transaction
  logic           s_req [MAXC];
  logic           s_flush [MAXC];
  logic           s_stall_in [MAXC];
  logic           s_ready [MAXC];
  logic [2*W-1:0] s_res [MAXC];
  logic           e_stall [MAXC];
  logic           e_start [MAXC];
  logic           e_annul [MAXC];
  logic           e_err [MAXC];
  logic           e_we [MAXC];
  logic [2*W-1:0] e_wdata [MAXC];
  logic [W-1:0]   e_opa [MAXC];
  logic [W-1:0]   e_opb [MAXC];
  logic           e_sgn [MAXC];

  int   cur_k  = 0;
  bit   chk_en = 1'b0;

  // Architectural values left behind by earlier transactions
  logic [2*W-1:0] last_wdata = 64'd0;
  logic [W-1:0]   last_opa   = 32'd0;
  logic [W-1:0]   last_opb   = 32'd0;
  logic           last_sgn   = 1'b0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cur_k, act, exp);
    end
  endtask

  // Reference divider: MIPS semantics, truncating toward zero; the stub
  // divider answers a zero divisor with {a, all-ones}.
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Per-cycle comparison against the expected timeline
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_div",  {63'd0, stall_div},  {63'd0, e_stall[cur_k]});
      check("div_start",  {63'd0, div_start},  {63'd0, e_start[cur_k]});
      check("div_annul",  {63'd0, div_annul},  {63'd0, e_annul[cur_k]});
      check("div_err",    {63'd0, div_err},    {63'd0, e_err[cur_k]});
      check("hilo_we",    {63'd0, hilo_we},    {63'd0, e_we[cur_k]});
      check("hilo_wdata", hilo_wdata,          e_wdata[cur_k]);
      check("div_opa",    {32'd0, div_opa},    {32'd0, e_opa[cur_k]});
      check("div_opb",    {32'd0, div_opb},    {32'd0, e_opb[cur_k]});
      check("div_signed", {63'd0, div_signed}, {63'd0, e_sgn[cur_k]});
    end
  end

  // lat: cycles from start to ready (<0 never); fb: BUSY cycle of flush (<=0 none)
  task automatic run_txn(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input int fb, input int stall_n, input bit done_flush);
    logic [2*W-1:0] res, fin;
    int  rb, fbc, end_c, d, x, n;
    bit  fast, aborted, tmo;
    res  = ref_div(sgn, a, b);
    fast = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast = (b == 32'd0);
`endif
    for (int k = 0; k < MAXC; k++) begin
      s_req[k]      = 1'b0;
      s_flush[k]    = 1'b0;
      s_stall_in[k] = 1'($urandom_range(0, 1));
      s_ready[k]    = 1'b0;
      s_res[k]      = {$urandom, $urandom};
      e_stall[k]    = 1'b0;
      e_start[k]    = 1'b0;
      e_annul[k]    = 1'b0;
      e_err[k]      = 1'b0;
      e_we[k]       = 1'b0;
      e_wdata[k]    = last_wdata;
      e_opa[k]      = (k >= 1) ? a : last_opa;
      e_opb[k]      = (k >= 1) ? b : last_opb;
      e_sgn[k]      = (k >= 1) ? sgn : last_sgn;
    end
    s_req[0]   = 1'b1;
    e_stall[0] = 1'b1;
    aborted    = 1'b0;
    tmo        = 1'b0;
    if (fast) begin
      end_c = 0;
      fin   = {a, 32'hFFFF_FFFF};
    end else begin
      e_start[1] = 1'b1;
      rb  = (lat >= 0) ? lat + 1 : NEVER;
      fbc = (fb > 0) ? fb : NEVER;
      end_c = TO;
      if (rb < end_c)  end_c = rb;
      if (fbc < end_c) end_c = fbc;
      aborted = (fbc == end_c);
      tmo     = !aborted && (rb != end_c);
      for (int k = 1; k <= end_c; k++) begin
        s_req[k]   = 1'($urandom_range(0, 1));
        e_stall[k] = 1'b1;
      end
      if (rb <= end_c) begin
        s_ready[rb] = 1'b1;
        s_res[rb]   = res;
      end
      if (aborted) s_flush[end_c] = 1'b1;
      fin = tmo ? 64'd0 : res;
    end
    if (aborted) begin
      e_annul[end_c + 1] = 1'b1;
      n = end_c + 3;
    end else begin
      d = end_c + 1;
      x = d + stall_n;
      if (tmo) begin
        e_annul[d] = 1'b1;
        e_err[d]   = 1'b1;
      end
      for (int k = d; k < MAXC; k++) e_wdata[k] = fin;
      for (int k = d; k <= x; k++) s_req[k] = 1'b1;
      for (int k = d; k < x; k++) s_stall_in[k] = 1'b1;
      if (done_flush) begin
        s_flush[x] = 1'b1;
      end else begin
        s_stall_in[x] = 1'b0;
        e_we[x]       = 1'b1;
      end
      last_wdata = fin;
      n = x + 3;
    end
    last_opa = a;
    last_opb = b;
    last_sgn = sgn;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      req_valid  = s_req[k];
      req_signed = (k == 0) ? sgn : 1'($urandom_range(0, 1));
      op_a       = (k == 0) ? a : $urandom;
      op_b       = (k == 0) ? b : $urandom;
      flush      = s_flush[k];
      stall_in   = s_stall_in[k];
      div_ready  = s_ready[k];
      div_result = s_res[k];
      cur_k      = k;
      chk_en     = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en    = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    stall_in  = 1'b0;
    div_ready = 1'b0;
  endtask

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    logic       sgn;
    logic [W-1:0] a, b;
    int lat, fb, sn;
    bit df;

    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; op_a = 32'd0; op_b = 32'd0;
    flush = 1'b0; stall_in = 1'b0; div_ready = 1'b0; div_result = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {div_start, div_signed, div_annul, div_err, stall_div, hilo_we}, 64'd0);
    check("rst_opa_opb", {div_opa, div_opb}, 64'd0);
    check("rst_wdata", hilo_wdata, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed values pinning the reference divider
    check("ref_7_2",    ref_div(1'b1, 32'd7, 32'd2),          64'h00000001_00000003);
    check("ref_m7_2",   ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),  64'hFFFFFFFF_FFFFFFFD);
    check("refu_m7_2",  ref_div(1'b0, 32'hFFFF_FFF9, 32'd2),  64'h00000001_7FFFFFFC);

    run_txn(1'b1, 32'd7, 32'd2, 32, 0, 0, 1'b0);
    check("div_7_2", hilo_wdata, 64'h00000001_00000003);
    run_txn(1'b1, 32'hFFFF_FFF9, 32'd2, 10, 0, 1, 1'b0);
    check("div_m7_2", hilo_wdata, 64'hFFFFFFFF_FFFFFFFD);
    run_txn(1'b0, 32'hFFFF_FFF9, 32'd2, 3, 0, 0, 1'b0);
    check("divu_m7_2", hilo_wdata, 64'h00000001_7FFFFFFC);
    run_txn(1'b1, 32'd100, 32'd7, 32, 5, 0, 1'b0);
    check("flush_busy_keeps", hilo_wdata, 64'h00000001_7FFFFFFC);
    run_txn(1'b0, 32'd100, 32'd7, 4, 5, 0, 1'b0);
    check("flush_ready_keeps", hilo_wdata, 64'h00000001_7FFFFFFC);
    run_txn(1'b0, 32'd100, 32'd7, 6, 0, 3, 1'b0);
    check("stall3_done", hilo_wdata, 64'h00000002_0000000E);
    run_txn(1'b1, 32'd9, 32'd3, -1, 0, 0, 1'b0);
    check("timeout_zero", hilo_wdata, 64'd0);
    run_txn(1'b0, 32'd5, 32'd0, 2, 0, 0, 1'b0);
    check("zero_div", hilo_wdata, 64'h00000005_FFFFFFFF);
    run_txn(1'b1, 32'd50, 32'd5, 0, 0, 2, 1'b1);

    for (int t = 0; t < 40; t++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
      fb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 44)) : 0;
      sn  = int'($urandom_range(0, 4));
      df  = ($urandom_range(0, 5) == 0);
      run_txn(sgn, a, b, lat, fb, sn, df);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative divider.
- Captures a DIV/DIVU request and launches the divider with a single start pulse.
- Holds the pipeline stalled until the divider is ready, then delivers the 64-bit {remainder, quotient} to the HI/LO write port exactly once.
- Handles flush (annul), an external pipeline stall while the result is held, and a watchdog timeout.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- TIMEOUT, 64, maximum BUSY cycles before the watchdog aborts; must be at least 2 and no more than 255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX holds a DIV/DIVU instruction.
- req_signed  in  1  1=DIV, 0=DIVU.
- op_a  in  WIDTH  dividend.
- op_b  in  WIDTH  divisor.
- flush  in  1  kill the EX instruction.
- stall_in  in  1  EX held by another stall source (e.g. mem).
- stall_div  out  1  stall request to the hazard unit.
- div_start  out  1  divider start pulse.
- div_signed  out  1  divider signed select.
- div_annul  out  1  divider abort.
- div_opa  out  WIDTH  latched dividend.
- div_opb  out  WIDTH  latched divisor.
- div_ready  in  1  divider result valid.
- div_result  in  2*WIDTH  {remainder, quotient}.
- hilo_we  out  1  HI/LO write enable.
- hilo_wdata  out  2*WIDTH  {HI, LO} = {remainder, quotient}.
- div_err  out  1  watchdog timeout pulse.

Behaviour:
- Reset: state IDLE, counter 0. All registered outputs are 0: div_start, div_signed, div_annul, div_opa, div_opb, hilo_wdata, div_err. stall_div=0 and hilo_we=0.
- States: IDLE, BUSY, DONE. Encodings are in the shared defines.
- IDLE:
  - stall_div = req_valid & ~flush (combinational), so the instruction stalls in its first EX cycle.
  - On req_valid & ~flush: latch op_a, op_b, req_signed into div_opa, div_opb, div_signed; go to BUSY; set div_start=1 for the next cycle only.
- BUSY:
  - stall_div=1.
  - div_start is high in the first BUSY cycle only, so a request never produces a second start.
  - The counter increments each BUSY cycle.
  - flush: div_annul=1 for one cycle; result dropped; go to IDLE. This wins over a simultaneous div_ready.
  - div_ready (no flush): capture div_result into hilo_wdata; go to DONE. Minimum latency is request cycle to DONE = 2 + divider latency.
  - Counter reaches TIMEOUT with no ready: div_annul=1 and div_err=1 for one cycle; hilo_wdata zeroed; go to DONE, so the instruction retires with HI/LO = 0.
- DONE:
  - stall_div=0.
  - hilo_we = ~stall_in & ~flush, a single pulse when the instruction leaves EX.
  - If stall_in=1, remain in DONE. Never restart the divider, never rewrite, hold hilo_wdata.
  - Exit to IDLE when ~stall_in or flush. On flush, no hilo_we.
- Back-to-back: a new request is accepted only from IDLE. A following DIV costs one IDLE cycle, which is stalled.
- req_valid dropping in BUSY without flush is ignored; flush is the only abort.
- rst mid-operation returns to IDLE with no annul pulse, because the divider shares rst.
- hilo_we is never asserted in IDLE or BUSY.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: in IDLE, a request with op_b==0 bypasses the divider.
  - No div_start.
  - hilo_wdata = {op_a, all-ones}.
  - Go directly to DONE next cycle; stall_div asserted for the request cycle only.
- Undefined: a zero divisor runs the divider normally. The result is whatever the divider returns (architecturally undefined).

Decomposition:
- Shared defines file:
  - state encodings DIV_IDLE/DIV_BUSY/DIV_DONE;
  - DivStart/DivStop constants;
  - the TIMEOUT default.
- No sub-module is natural. The watchdog counter and FSM are inline.
- The ALU instantiates div_seq_ctrl alongside the divider.

Test Plan:
- Signed 7/2, divider ready 32 cycles after start:
  - div_start high exactly 1 cycle;
  - stall_div high through BUSY;
  - hilo_wdata=64'h00000001_00000003;
  - hilo_we one cycle.
- Signed -7/2 (op_a=32'hFFFFFFF9):
  - hilo_wdata=64'hFFFFFFFF_FFFFFFFD.
  - DIVU with the same operands gives quotient 32'h7FFFFFFC and remainder 1.
- flush in BUSY cycle 5:
  - div_annul one pulse; IDLE next cycle;
  - no hilo_we;
  - flush coincident with div_ready also gives no hilo_we.
- stall_in held 3 cycles in DONE:
  - single div_start total;
  - hilo_we only on the cycle stall_in drops;
  - hilo_wdata stable throughout.
- div_ready never asserted, TIMEOUT=64:
  - div_err and div_annul pulse after 64 BUSY cycles;
  - hilo_we with hilo_wdata=0.
- DIV_ZERO_FAST_EN with op_a=5, op_b=0:
  - no div_start;
  - hilo_wdata=64'h00000005_FFFFFFFF;
  - stall_div one cycle.
